// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared timing definitions for the video timing generator.
// Holds per-axis mode descriptors for common CEA modes and the total-length helpers.
package video_timing_pkg;

  // One axis (horizontal or vertical) of a video mode. pol = 1 means the sync is active high.
  typedef struct packed {
    logic [15:0] sync;
    logic [15:0] back;
    logic [15:0] disp;
    logic [15:0] front;
    logic        pol;
  } axis_t;

  localparam axis_t MODE_480P_H   = '{sync: 16'd96, back: 16'd48,  disp: 16'd640,
                                      front: 16'd16, pol: 1'b0};
  localparam axis_t MODE_480P_V   = '{sync: 16'd2,  back: 16'd33,  disp: 16'd480,
                                      front: 16'd10, pol: 1'b0};
  localparam axis_t MODE_720P_H   = '{sync: 16'd40, back: 16'd220, disp: 16'd1280,
                                      front: 16'd110, pol: 1'b1};
  localparam axis_t MODE_720P_V   = '{sync: 16'd5,  back: 16'd20,  disp: 16'd720,
                                      front: 16'd5, pol: 1'b1};
  localparam axis_t MODE_1080P_H  = '{sync: 16'd44, back: 16'd148, disp: 16'd1920,
                                      front: 16'd88, pol: 1'b1};
  localparam axis_t MODE_1080P_V  = '{sync: 16'd5,  back: 16'd36,  disp: 16'd1080,
                                      front: 16'd4, pol: 1'b1};

  // Total period of one axis in pixels or lines.
  function automatic int unsigned line_total(input int unsigned sync, input int unsigned back,
                                             input int unsigned disp, input int unsigned front);
    return sync + back + disp + front;
  endfunction

  function automatic int unsigned axis_total(input axis_t a);
    return line_total(32'(a.sync), 32'(a.back), 32'(a.disp), 32'(a.front));
  endfunction

endpackage

// File: rtl/video_sync_delay.sv
// video_sync_delay: parametrised-depth shift register used as the output alignment stage
// for the sync/DE/frame-start strobes.
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset, loads RST_VAL into every stage
//   i_clr   - synchronous flush of every stage to RST_VAL
//   i_d     - input word
//   o_q     - word delayed by DEPTH cycles
module video_sync_delay #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= RST_VAL;
    end else if (i_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised HSYNC/VSYNC/DE timing generator with pixel request lead.
// Every output is a registered decode of the counter value being loaded on the same edge,
// so output cycle k reflects counter value k.
// Ports:
//   i_pixel_clk   - pixel clock
//   i_rst_n       - asynchronous active-low reset
//   i_enable      - run timing; low forces idle on the next edge
//   i_pixel_data  - pixel for the position requested REQ_LEAD-1 cycles earlier
//   o_data_req    - pixel request strobe
//   o_pixel_xpos  - requested column (0 when no request)
//   o_pixel_ypos  - requested row (0 when no request)
//   o_video_hs    - horizontal sync, polarity HS_POL
//   o_video_vs    - vertical sync, polarity VS_POL
//   o_video_de    - active video
//   o_video_rgb   - pixel out, 0 outside DE
//   o_frame_start - one-cycle pulse on the first cycle of each frame
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BACK   = 220,
  parameter int unsigned H_DISP   = 1280,
  parameter int unsigned H_FRONT  = 110,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BACK   = 20,
  parameter int unsigned V_DISP   = 720,
  parameter int unsigned V_FRONT  = 5,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned REQ_LEAD = 1,
  parameter int unsigned CNT_W    = 12
) (
  input  logic              i_pixel_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_pixel_data,
  output logic              o_data_req,
  output logic [CNT_W-1:0]  o_pixel_xpos,
  output logic [CNT_W-1:0]  o_pixel_ypos,
  output logic              o_video_hs,
  output logic              o_video_vs,
  output logic              o_video_de,
  output logic [DATA_W-1:0] o_video_rgb,
  output logic              o_frame_start
);

  localparam int unsigned H_TOTAL = line_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int unsigned V_TOTAL = line_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam int unsigned HA      = H_SYNC + H_BACK;
  localparam int unsigned VA      = V_SYNC + V_BACK;

  if (REQ_LEAD < 1 || REQ_LEAD > H_BACK) begin : g_bad_req_lead
    $error("video_timing_gen: REQ_LEAD must lie in 1..H_BACK");
  end
  if (longint'(H_TOTAL) >= (longint'(1) << CNT_W)) begin : g_bad_h_total
    $error("video_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (longint'(V_TOTAL) >= (longint'(1) << CNT_W)) begin : g_bad_v_total
    $error("video_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_HSYNC  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] C_VSYNC  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] C_HA     = CNT_W'(HA);
  localparam logic [CNT_W-1:0] C_HE     = CNT_W'(HA + H_DISP);
  localparam logic [CNT_W-1:0] C_RQS    = CNT_W'(HA - REQ_LEAD);
  localparam logic [CNT_W-1:0] C_RQE    = CNT_W'(HA + H_DISP - REQ_LEAD);
  localparam logic [CNT_W-1:0] C_VA     = CNT_W'(VA);
  localparam logic [CNT_W-1:0] C_VE     = CNT_W'(VA + V_DISP);

  // Strobe bundle order: {hs level, vs level, de, frame_start}.
  localparam logic [3:0] SYNC_RST = {~HS_POL, ~VS_POL, 2'b00};

  logic              r_run;
  logic [CNT_W-1:0]  r_h_cnt;
  logic [CNT_W-1:0]  r_v_cnt;
  logic              r_data_req;
  logic [CNT_W-1:0]  r_pixel_xpos;
  logic [CNT_W-1:0]  r_pixel_ypos;
  logic [DATA_W-1:0] r_video_rgb;

  logic [CNT_W-1:0]  w_h_nxt;
  logic [CNT_W-1:0]  w_v_nxt;
  logic              w_line_act;
  logic              w_de;
  logic              w_req;
  logic              w_hs_act;
  logic              w_vs_act;
  logic              w_fs;
  logic [3:0]        w_strobe_d;
  logic [3:0]        w_strobe_q;

  // Counter value for the coming cycle. The first enabled edge after idle loads frame cycle 0,
  // so the cycle after enable rises is always the start of a frame.
  always_comb begin
    w_h_nxt = '0;
    w_v_nxt = '0;
    if (i_enable && r_run) begin
      if (r_h_cnt == C_H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + C_ONE;
      end else begin
        w_h_nxt = r_h_cnt + C_ONE;
        w_v_nxt = r_v_cnt;
      end
    end
  end

  // Decodes of the coming counter value; all gated by enable so idle matches reset.
  always_comb begin
    w_line_act = (w_v_nxt >= C_VA) && (w_v_nxt < C_VE);
    w_de       = i_enable && w_line_act && (w_h_nxt >= C_HA) && (w_h_nxt < C_HE);
    w_req      = i_enable && w_line_act && (w_h_nxt >= C_RQS) && (w_h_nxt < C_RQE);
    w_hs_act   = i_enable && (w_h_nxt < C_HSYNC);
    w_vs_act   = i_enable && (w_v_nxt < C_VSYNC);
    w_fs       = i_enable && (w_h_nxt == '0) && (w_v_nxt == '0);
    w_strobe_d = {(w_hs_act ? HS_POL : ~HS_POL), (w_vs_act ? VS_POL : ~VS_POL), w_de, w_fs};
  end

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run        <= 1'b0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_data_req   <= 1'b0;
      r_pixel_xpos <= '0;
      r_pixel_ypos <= '0;
      r_video_rgb  <= '0;
    end else begin
      r_run        <= i_enable;
      r_h_cnt      <= w_h_nxt;
      r_v_cnt      <= w_v_nxt;
      r_data_req   <= w_req;
      r_pixel_xpos <= w_req ? (w_h_nxt - C_RQS) : '0;
      r_pixel_ypos <= w_req ? (w_v_nxt - C_VA) : '0;
      // Pixel is captured on the edge that raises DE for it; it arrives REQ_LEAD-1 cycles
      // after its request.
      r_video_rgb  <= w_de ? i_pixel_data : '0;
    end
  end

  video_sync_delay #(
    .WIDTH   (4),
    .DEPTH   (1),
    .RST_VAL (SYNC_RST)
  ) u_sync_delay (
    .i_clk   (i_pixel_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (~i_enable),
    .i_d     (w_strobe_d),
    .o_q     (w_strobe_q)
  );

  assign o_video_hs    = w_strobe_q[3];
  assign o_video_vs    = w_strobe_q[2];
  assign o_video_de    = w_strobe_q[1];
  assign o_frame_start = w_strobe_q[0];
  assign o_data_req    = r_data_req;
  assign o_pixel_xpos  = r_pixel_xpos;
  assign o_pixel_ypos  = r_pixel_ypos;
  assign o_video_rgb   = r_video_rgb;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a 10x5 mode with REQ_LEAD = 2, one instance with
// active-high syncs and one with active-low syncs driven from the same stimulus.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [23:0] pixel_data = 24'hFFFFFF;

  logic        req, hs, vs, de, fs;
  logic [11:0] xpos, ypos;
  logic [23:0] rgb;
  logic        req_n, hs_n, vs_n, de_n, fs_n;
  logic [11:0] xpos_n, ypos_n;
  logic [23:0] rgb_n;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISP(2), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .DATA_W(24), .REQ_LEAD(2), .CNT_W(12)
  ) dut (
    .i_pixel_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_pixel_data(pixel_data),
    .o_data_req(req), .o_pixel_xpos(xpos), .o_pixel_ypos(ypos), .o_video_hs(hs),
    .o_video_vs(vs), .o_video_de(de), .o_video_rgb(rgb), .o_frame_start(fs)
  );

  video_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_DISP(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISP(2), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_W(24), .REQ_LEAD(2), .CNT_W(12)
  ) dut_n (
    .i_pixel_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_pixel_data(pixel_data),
    .o_data_req(req_n), .o_pixel_xpos(xpos_n), .o_pixel_ypos(ypos_n), .o_video_hs(hs_n),
    .o_video_vs(vs_n), .o_video_de(de_n), .o_video_rgb(rgb_n), .o_frame_start(fs_n)
  );

  typedef struct packed {
    logic        hs, vs, de, req, fs;
    logic [11:0] x, y;
    logic [23:0] rgb;
    logic        hs_n, vs_n, de_n, req_n, fs_n;
    logic [11:0] x_n, y_n;
    logic [23:0] rgb_n;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   fs_t[$];
  logic [23:0] rgb_seen[$];

  bit m_run = 0;
  int m_h = 0;
  int m_v = 0;

  // Hand-derived frame: HA = 5, DE at h 5..8, requests at h 3..6, active lines v = 2,3.
  function automatic obs_t expect_at(input bit act, input int h, input int v);
    obs_t e;
    bit   line;
    e = '0;
    e.hs_n = 1'b1;
    e.vs_n = 1'b1;
    if (act) begin
      line    = (v == 2) || (v == 3);
      e.hs    = (h < 2);
      e.vs    = (v < 1);
      e.de    = line && (h >= 5) && (h <= 8);
      e.req   = line && (h >= 3) && (h <= 6);
      e.fs    = (h == 0) && (v == 0);
      e.x     = e.req ? 12'(h - 3) : 12'd0;
      e.y     = e.req ? 12'(v - 2) : 12'd0;
      e.rgb   = e.de ? {12'(v - 2), 12'(h - 5)} : 24'd0;
      e.hs_n  = ~e.hs;
      e.vs_n  = ~e.vs;
      e.de_n  = e.de;
      e.req_n = e.req;
      e.fs_n  = e.fs;
      e.x_n   = e.x;
      e.y_n   = e.y;
      e.rgb_n = e.rgb;
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.hs = hs;     a.vs = vs;     a.de = de;     a.req = req;     a.fs = fs;
    a.x = xpos;    a.y = ypos;    a.rgb = rgb;
    a.hs_n = hs_n; a.vs_n = vs_n; a.de_n = de_n; a.req_n = req_n; a.fs_n = fs_n;
    a.x_n = xpos_n; a.y_n = ypos_n; a.rgb_n = rgb_n;
    return a;
  endfunction

  // Drive enable for the next edge and push the response that edge must produce.
  task automatic tick(input logic en);
    enable = en;
    if (!rst_n || !en) begin
      m_run = 0; m_h = 0; m_v = 0;
      exp_q.push_back(expect_at(1'b0, 0, 0));
    end else if (!m_run) begin
      m_run = 1; m_h = 0; m_v = 0;
      exp_q.push_back(expect_at(1'b1, 0, 0));
    end else begin
      m_h++;
      if (m_h == 10) begin
        m_h = 0;
        m_v = (m_v == 4) ? 0 : m_v + 1;
      end
      exp_q.push_back(expect_at(1'b1, m_h, m_v));
    end
    @(posedge clk);
    #1;
  endtask

  // Pixel source: answers a request one cycle later, drives all-ones when nothing is requested.
  initial begin
    logic        s_req;
    logic [11:0] s_x, s_y;
    forever begin
      @(negedge clk);
      s_req = req; s_x = xpos; s_y = ypos;
      @(posedge clk);
      #1;
      pixel_data = s_req ? {s_y, s_x} : 24'hFFFFFF;
    end
  end

  // Monitor: every cycle the DUTs present a full output set, compared against the queue head.
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    cyc++;
    a = sample();
    if (a.de) rgb_seen.push_back(a.rgb);
    if (a.fs) fs_t.push_back(cyc);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got %h want %h", cyc, a, e);
      end
    end
  end

  initial begin
    logic [23:0] want_rgb [8];
    obs_t a;
    obs_t e;
    want_rgb = '{24'h000000, 24'h000001, 24'h000002, 24'h000003,
                 24'h001000, 24'h001001, 24'h001002, 24'h001003};

    // Reset held (enable already high), then released: two full frames.
    repeat (3) tick(1'b1);
    rst_n = 1'b1;
    repeat (110) tick(1'b1);

    // Drop enable while showing h=6 of line 2, then re-enable.
    for (int i = 0; i < 60 && !(m_h == 6 && m_v == 2); i++) tick(1'b1);
    repeat (3) tick(1'b0);
    repeat (60) tick(1'b1);

    // Asynchronous reset in the middle of a DE cycle.
    for (int i = 0; i < 60 && !(m_h == 6 && m_v == 2); i++) tick(1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    a = sample();
    e = expect_at(1'b0, 0, 0);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", a, e);
    end
    repeat (2) tick(1'b1);
    rst_n = 1'b1;
    repeat (20) tick(1'b1);
    @(negedge clk);
    #1;

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    n_tests++;
    if (fs_t.size() < 2 || (fs_t[1] - fs_t[0]) != 50) begin
      n_fail++;
      $display("FAIL frame_period: got %0d pulses gap %0d want gap 50", fs_t.size(),
               (fs_t.size() < 2) ? -1 : fs_t[1] - fs_t[0]);
    end

    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (rgb_seen.size() <= i || rgb_seen[i] !== want_rgb[i]) begin
        n_fail++;
        $display("FAIL rgb_seq[%0d]: got %h want %h", i,
                 (rgb_seen.size() > i) ? rgb_seen[i] : 24'hxxxxxx, want_rgb[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
